// File: rtl/dtree_pkg.sv
// Shared types and defaults for the decision-tree wrapper blocks.
package dtree_pkg;

  localparam int unsigned FEAT_W_DEF  = 8;
  localparam int unsigned CLASS_W_DEF = 5;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef logic [FEAT_W_DEF-1:0] feat_t;

endpackage

// File: rtl/dtree_settle_timer.sv
// Loadable down-counter that flags the last cycle of a fixed settle window.
// done_c is high during the final enabled cycle; the count stops at zero.
module dtree_settle_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Reload on entry to the window, count down while enabled, hold at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(CYCLES);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done_c = en && (cnt == CNT_W'(1));

endmodule

// File: rtl/dtree_feature_loader.sv
// Feature-vector loader and class-result capture around a combinational
// decision tree. Optional handoff statistics are enabled by defining
// DTREE_LOADER_STATS_EN.
module dtree_feature_loader
  import dtree_pkg::*;
#(
  parameter int unsigned NUM_FEATURES  = 5,
  parameter int unsigned FEAT_W        = FEAT_W_DEF,
  parameter int unsigned CLASS_W       = CLASS_W_DEF,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FEAT_W-1:0]              in_data,
  input  logic                           in_last,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_o,
  input  logic [CLASS_W-1:0]             class_i,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CLASS_W-1:0]             out_class,
`ifdef DTREE_LOADER_STATS_EN
  output logic                           out_err,
  output logic [15:0]                    stat_frames,
  output logic [15:0]                    stat_errs
`else
  output logic                           out_err
`endif
);

  localparam int unsigned IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned VEC_W = NUM_FEATURES * FEAT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [VEC_W-1:0]   feat_n;
  logic               err_flag, err_n;
  logic [CLASS_W-1:0] class_n;
  logic               res_err_n;
  logic               beat_c;
  logic               settle_load_c;
  logic               settle_done_c;

  assign beat_c        = in_valid & in_ready;
  assign settle_load_c = (state_n == SETTLE) && (state != SETTLE);

  // Settle window for the external tree logic.
  dtree_settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (settle_load_c),
    .en     (state == SETTLE),
    .done_c (settle_done_c)
  );

  // Next-state, slot writes, frame-error tracking and result capture.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    feat_n    = feat_o;
    err_n     = err_flag;
    class_n   = out_class;
    res_err_n = out_err;
    unique case (state)
      LOAD: begin
        if (beat_c) begin
          for (int k = 0; k < NUM_FEATURES; k++) begin
            if (IDX_W'(k) == idx) begin
              feat_n[k*FEAT_W +: FEAT_W] = in_data;
            end else if (in_last && (IDX_W'(k) > idx)) begin
              // Short frame: slots never written this frame read as zero.
              feat_n[k*FEAT_W +: FEAT_W] = '0;
            end
          end
          if (in_last) begin
            if (idx != LAST_IDX) begin
              err_n = 1'b1;
            end
            state_n = SETTLE;
          end else if (idx == LAST_IDX) begin
            err_n   = 1'b1;
            state_n = DRAIN;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (beat_c && in_last) begin
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_done_c) begin
          class_n   = class_i;
          res_err_n = err_flag;
          state_n   = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = LOAD;
          idx_n   = '0;
          err_n   = 1'b0;
        end
      end
      default: begin
        state_n = LOAD;
      end
    endcase
  end

  // State and registered outputs; ready/valid follow the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      feat_o    <= '0;
      err_flag  <= 1'b0;
      out_class <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      feat_o    <= feat_n;
      err_flag  <= err_n;
      out_class <= class_n;
      out_err   <= res_err_n;
      out_valid <= (state_n == HOLD);
      in_ready  <= (state_n == LOAD) || (state_n == DRAIN);
    end
  end

`ifdef DTREE_LOADER_STATS_EN
  // Saturating counts of delivered results and delivered error results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_errs   <= '0;
    end else if (out_valid && out_ready) begin
      if (stat_frames != 16'hFFFF) begin
        stat_frames <= stat_frames + 16'd1;
      end
      if (out_err && (stat_errs != 16'hFFFF)) begin
        stat_errs <= stat_errs + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Directed bench for dtree_feature_loader with a tree stub
// returning feature 4 bits [4:0] as the class.
module tb_dtree_feature_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [39:0] feat_o;
  logic [4:0]  class_i;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_class;
  logic        out_err;
`ifdef DTREE_LOADER_STATS_EN
  logic [15:0] stat_frames;
  logic [15:0] stat_errs;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign class_i = feat_o[36:32];

  dtree_feature_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .feat_o      (feat_o),
    .class_i     (class_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_class   (out_class),
`ifdef DTREE_LOADER_STATS_EN
    .out_err     (out_err),
    .stat_frames (stat_frames),
    .stat_errs   (stat_errs)
`else
    .out_err     (out_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("beat_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("out_valid_wait", 64'(out_valid), 64'd1);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic stable;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_class", 64'(out_class), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_feat", 64'(feat_o), 64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Normal frame and latency
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b0);
    send_beat(8'h30, 1'b0);
    send_beat(8'h40, 1'b0);
    send_beat(8'h50, 1'b1);
    check("lat_c1", 64'(out_valid), 64'd0);
    step();
    check("lat_c2", 64'(out_valid), 64'd0);
    step();
    check("lat_c3", 64'(out_valid), 64'd1);
    check("norm_class", 64'(out_class), 64'h10);
    check("norm_err", 64'(out_err), 64'd0);
    check("norm_feat", 64'(feat_o), 64'h50_4030_2010);
    check("norm_in_ready", 64'(in_ready), 64'd0);

    // Backpressure: result stable, no input accepted
    stable = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b1 || out_class !== 5'h10 || out_err !== 1'b0 ||
          in_ready !== 1'b0 || feat_o !== 40'h50_4030_2010)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("bp_stable", 64'(stable), 64'd1);
    handoff();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);

    // out_ready while idle has no effect
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check("idle_ready_valid", 64'(out_valid), 64'd0);

    // Short frame
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b1);
    wait_valid();
    check("short_feat", 64'(feat_o), 64'h00_0033_2211);
    check("short_class", 64'(out_class), 64'h00);
    check("short_err", 64'(out_err), 64'd1);
    handoff();

    // Long frame
    for (int i = 1; i <= 6; i++) send_beat(8'(i), 1'b0);
    check("long_drain_feat", 64'(feat_o), 64'h05_0403_0201);
    send_beat(8'h07, 1'b1);
    wait_valid();
    check("long_feat", 64'(feat_o), 64'h05_0403_0201);
    check("long_class", 64'(out_class), 64'h05);
    check("long_err", 64'(out_err), 64'd1);
    handoff();

    // Reset mid-frame
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b0);
    rst_n = 1'b0;
    step();
    check("mid_rst_feat", 64'(feat_o), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    step();
    send_beat(8'h1F, 1'b0);
    send_beat(8'h2E, 1'b0);
    send_beat(8'h3D, 1'b0);
    send_beat(8'h4C, 1'b0);
    send_beat(8'h5B, 1'b1);
    wait_valid();
    check("after_rst_feat", 64'(feat_o), 64'h5B_4C3D_2E1F);
    check("after_rst_class", 64'(out_class), 64'h1B);
    check("after_rst_err", 64'(out_err), 64'd0);
    handoff();

`ifdef DTREE_LOADER_STATS_EN
    send_beat(8'h01, 1'b1);
    wait_valid();
    handoff();
    check("stat_frames", 64'(stat_frames), 64'd2);
    check("stat_errs", 64'(stat_errs), 64'd1);
    force dut.stat_frames = 16'hFFFF;
    force dut.stat_errs   = 16'hFFFF;
    step();
    release dut.stat_frames;
    release dut.stat_errs;
    send_beat(8'h02, 1'b1);
    wait_valid();
    handoff();
    step();
    check("stat_frames_sat", 64'(stat_frames), 64'hFFFF);
    check("stat_errs_sat", 64'(stat_errs), 64'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
